// File: rtl/parity_stream_unit_if.sv
// Word stream bundle for parity_stream_unit: upstream valid/ready and downstream
// registered output, including parity, error flag and frame LRC.
interface parity_stream_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_par;
  logic             out_err;
  logic             out_last;
  logic [WIDTH-1:0] out_lrc;

  modport master (
    output in_valid, in_data, in_par, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_err, out_last, out_lrc
  );

  modport slave (
    input  in_valid, in_data, in_par, in_last, out_ready,
    output in_ready, out_valid, out_data, out_par, out_err, out_last, out_lrc
  );
endinterface

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with per-frame column parity (LRC) and
// sticky/saturating error statistics; one registered output stage.
module parity_stream_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  even_odd,
  input  logic                  check_en,
  input  logic                  clr_err,
  parity_stream_unit_if.slave   bus,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      err_count
);

  logic             accept;
  logic             par_calc;
  logic             mismatch;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lrc_next;

  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    par_calc = even_odd ? (^bus.in_data) : (~^bus.in_data);
    mismatch = accept & check_en & (par_calc != bus.in_par);
    lrc_next = acc ^ bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_par   <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_lrc   <= '0;
      acc           <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data;
      bus.out_last  <= bus.in_last;
      bus.out_par   <= check_en ? bus.in_par : par_calc;
      bus.out_err   <= check_en & (par_calc != bus.in_par);
      bus.out_lrc   <= lrc_next;
      acc           <= bus.in_last ? '0 : lrc_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // A mismatch accepted alongside clr_err survives the clear as a fresh count of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (clr_err) begin
      err_sticky <= mismatch;
      err_count  <= mismatch ? CNT_W'(1) : '0;
    end else if (mismatch) begin
      err_sticky <= 1'b1;
      if (err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed self-checking bench for parity_stream_unit: vector table for single
// words and frames, plus hand sequences for clear, backpressure, saturation, reset.
module tb_parity_stream_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       even_odd, check_en, clr_err;
  logic       err_sticky;
  logic [7:0] err_count;
  logic       even_odd2, check_en2, clr_err2;
  logic       err_sticky2;
  logic [1:0] err_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parity_stream_unit_if #(.WIDTH(8)) bus ();
  parity_stream_unit_if #(.WIDTH(8)) bus2 ();

  parity_stream_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .even_odd(even_odd), .check_en(check_en),
    .clr_err(clr_err), .bus(bus), .err_sticky(err_sticky), .err_count(err_count)
  );

  parity_stream_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .even_odd(even_odd2), .check_en(check_en2),
    .clr_err(clr_err2), .bus(bus2), .err_sticky(err_sticky2), .err_count(err_count2)
  );

  typedef struct {
    logic       eo;
    logic       ce;
    logic [7:0] d;
    logic       p;
    logic       l;
    logic       x_par;
    logic       x_err;
    logic       x_last;
    logic [7:0] x_lrc;
    logic [7:0] x_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the word is accepted on the next posedge and the
  // task returns at the following negedge with in_valid dropped.
  task automatic send(input logic eo, input logic ce, input logic [7:0] d,
                      input logic p, input logic l);
    even_odd     = eo;
    check_en     = ce;
    bus.in_data  = d;
    bus.in_par   = p;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // eo ce data  par last | x_par x_err x_last x_lrc x_cnt
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 8'd1};
    tbl[5]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'd1};
    tbl[7]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 8'd2};
    tbl[11] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'd3};

    rst = 1'b1;
    even_odd = 1'b1; check_en = 1'b0; clr_err = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_par = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    even_odd2 = 1'b1; check_en2 = 1'b1; clr_err2 = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_par = 1'b0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_lrc",   32'(bus.out_lrc),   32'd0);
    chk("rst_err_count", 32'(err_count),     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].eo, tbl[i].ce, tbl[i].d, tbl[i].p, tbl[i].l);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(tbl[i].d));
      chk($sformatf("vec%0d_par", i),   32'(bus.out_par),   32'(tbl[i].x_par));
      chk($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(tbl[i].x_err));
      chk($sformatf("vec%0d_last", i),  32'(bus.out_last),  32'(tbl[i].x_last));
      chk($sformatf("vec%0d_lrc", i),   32'(bus.out_lrc),   32'(tbl[i].x_lrc));
      chk($sformatf("vec%0d_cnt", i),   32'(err_count),     32'(tbl[i].x_cnt));
      chk($sformatf("vec%0d_sticky", i), 32'(err_sticky),  32'(tbl[i].x_cnt != 0));
    end

    @(negedge clk);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // clr_err alone
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_count",  32'(err_count),  32'd0);

    // clr_err together with a mismatching word
    clr_err = 1'b1;
    send(1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
    clr_err = 1'b0;
    chk("clrerr_sticky", 32'(err_sticky), 32'd1);
    chk("clrerr_count",  32'(err_count),  32'd1);
    chk("clrerr_out_err", 32'(bus.out_err), 32'd1);
    @(negedge clk);

    // Backpressure: 0x5A held while 0x3C waits
    bus.out_ready = 1'b0;
    even_odd = 1'b1; check_en = 1'b0;
    bus.in_data = 8'h5A; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_data = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_out_data", c),  32'(bus.out_data),  32'h5A);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_data",  32'(bus.out_data),  32'h3C);
    @(negedge clk);
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Saturating 2-bit counter on the second instance
    bus2.in_data = 8'h07; bus2.in_par = 1'b0; bus2.in_last = 1'b1; bus2.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_count", k), 32'(err_count2), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("sat%0d_sticky", k), 32'(err_sticky2), 32'd1);
    end
    bus2.in_valid = 1'b0;

    // Reset in the middle of a frame with an output word pending
    send(1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
    send(1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data",  32'(bus.out_data),  32'd0);
    chk("mrst_out_par",   32'(bus.out_par),   32'd0);
    chk("mrst_out_err",   32'(bus.out_err),   32'd0);
    chk("mrst_out_last",  32'(bus.out_last),  32'd0);
    chk("mrst_out_lrc",   32'(bus.out_lrc),   32'd0);
    chk("mrst_sticky",    32'(err_sticky),    32'd0);
    chk("mrst_count",     32'(err_count),     32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    send(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
    chk("post_rst_lrc",  32'(bus.out_lrc),  32'h3C);
    chk("post_rst_last", 32'(bus.out_last), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_stream_unit.md
# parity_stream_unit

Streaming, parametrised parity generator/checker with valid/ready handshakes, per-frame longitudinal (column) parity, and error statistics. It accepts one WIDTH-bit word per cycle. In generate mode it appends a parity bit; in check mode it verifies a received parity bit. It sits between a word source (e.g. a deserialiser) and the downstream consumer, and it replaces the fixed 8-bit combinational parity function used so far.

## Interface

Parameters:
- WIDTH, 8, data word width (≥2)
- CNT_W, 8, width of the saturating error counter (≥1)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- even_odd  in  1  1 = even parity (parity bit = ^data); 0 = odd parity (parity bit = ~^data)
- check_en  in  1  0 = generate mode; 1 = check mode
- clr_err  in  1  single-cycle clear of err_sticky and err_count
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  input word
- in_par  in  1  received parity bit (used in check mode only)
- in_last  in  1  word is the last of a frame
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the output word
- out_data  out  WIDTH  registered copy of the accepted word
- out_par  out  1  generate mode: computed parity; check mode: in_par passed through
- out_err  out  1  check mode: parity mismatch on this word; generate mode: 0
- out_last  out  1  registered in_last
- out_lrc  out  WIDTH  column XOR of all words in the frame; meaningful only when out_valid & out_last
- err_sticky  out  1  set by any mismatch; held until clr_err or rst
- err_count  out  CNT_W  number of mismatches, saturating at 2^CNT_W−1

## Operation

- Acceptance: a word is accepted on a rising edge when in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational).
- even_odd and check_en are sampled per word at acceptance. Changing them mid-frame is legal and affects only later words.
- Computed parity p: ^in_data when even_odd=1, ~^in_data when even_odd=0.
- On acceptance, the output register loads:
  - out_data = in_data
  - out_last = in_last
  - generate mode: out_par = p, out_err = 0
  - check mode: out_par = in_par, out_err = (p != in_par)
- LRC accumulator acc (WIDTH bits, 0 at frame start):
  - On a non-last accepted word: acc ← acc ^ in_data, and out_lrc loads acc ^ in_data.
  - On a last word: out_lrc loads acc ^ in_data, and acc ← 0.
  - A new frame begins after rst or after any accepted word with in_last=1.
  - out_lrc is raw column XOR, independent of even_odd.
- Error statistics, updated on the same edge as acceptance:
  - If the accepted word has a mismatch: err_sticky ← 1, and err_count increments unless it is already all-ones.
  - clr_err alone: err_sticky ← 0, err_count ← 0.
  - clr_err together with a mismatching accepted word: err_sticky ← 1, err_count ← 1 (the new error survives the clear).
- Output register: out_valid is set on acceptance. It is cleared when out_valid & out_ready and no new acceptance happens in that cycle. While out_valid & ~out_ready, all out_* signals hold stable.

## Timing

- Reset values: in_ready=1 (after the reset edge), out_valid=0, out_data=0, out_par=0, out_err=0, out_last=0, out_lrc=0, acc=0, err_sticky=0, err_count=0.
- rst takes priority over all other inputs. Reset mid-frame discards the partial frame and any pending output word.
- Latency: 1 cycle from the acceptance edge to out_valid=1 with data present.
- Throughput: 1 word/cycle while out_ready=1. An output transfer and a new acceptance in the same cycle reload the register with no bubble.
- err_sticky and err_count reflect a word's error on the same edge that its out_valid rises.
- No combinational path from in_valid or in_data to any output. The only combinational path is out_ready → in_ready.

## Test plan

All scenarios use WIDTH=8.

1. Generate mode, even_odd=1, words 0xA5 then 0x07 with out_ready=1 → out_par 0 then 1, one cycle after each acceptance. Repeat with even_odd=0 → 1 then 0. out_err stays 0.
2. Check mode, even_odd=1: send 0x07 with in_par=0, then 0xA5 with in_par=0 → out_err=1 then 0. err_sticky=1, err_count=1. Pulse clr_err → both return to 0 next cycle. Then pulse clr_err in the same cycle as a mismatching word → count=1, sticky=1.
3. Frame 0x0F, 0xF0, 0x3C (last on 0x3C) → out_lrc=0xC3 with out_last=1. The following frame 0x11 (last) → out_lrc=0x11, which confirms the accumulator cleared.
4. Backpressure: accept 0x5A, hold out_ready=0 for 3 cycles with in_valid=1 and in_data=0x3C → in_ready=0 and out_data stays 0x5A throughout. Raise out_ready → 0x5A transfers and 0x3C is accepted on the same edge. No word is lost or duplicated.
5. CNT_W=2, check mode, 5 consecutive mismatching words → err_count sequence 1, 2, 3, 3, 3, with err_sticky=1.
6. Accept 0x0F and 0xF0 (not last), assert rst for one cycle with out_valid=1, then send 0x3C with last → all outputs read their reset values during reset, and the new frame reports out_lrc=0x3C.
